// File: rtl/mips_reg_file.sv
// Two-read / one-write register file with a hardwired-zero entry 0 and an
// optional same-cycle write-to-read forwarding path for the WB->ID hazard.
module mips_reg_file #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter bit WRITE_BYPASS = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  input  logic [ADDR_WIDTH-1:0] rd,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  write_enable,
  output logic [DATA_WIDTH-1:0] rs1_data,
  output logic [DATA_WIDTH-1:0] rs2_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic                  wr_live;

  // write_enable is tested first so an X/Z rd cannot select an entry while idle
  assign wr_live = write_enable && !rst && (rd != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (write_enable && (rd != '0)) begin
      regs[rd] <= write_data;
    end
  end

  logic [ADDR_WIDTH-1:0] raddr [2];
  logic [DATA_WIDTH-1:0] rdata [2];

  assign raddr[0] = rs1;
  assign raddr[1] = rs2;
  assign rs1_data = rdata[0];
  assign rs2_data = rdata[1];

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic [DATA_WIDTH-1:0] stored;
    assign stored = (raddr[p] == '0) ? '0 : regs[raddr[p]];
    if (WRITE_BYPASS) begin : g_byp
      assign rdata[p] = (wr_live && (rd == raddr[p])) ? write_data : stored;
    end else begin : g_nobyp
      assign rdata[p] = stored;
    end
  end

endmodule

// File: tb/tb_mips_reg_file.sv
// Table-driven directed vectors plus randomized traffic against an array
// model; bypassing and non-bypassing instances share the same stimulus.
module tb_mips_reg_file;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] write_data;
  logic        write_enable;
  logic [31:0] rs1_data, rs2_data, rs1_data_nb, rs2_data_nb;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] mdl [32];

  always #5 clk = ~clk;

  mips_reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .WRITE_BYPASS(1)) dut (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .rd(rd),
    .write_data(write_data), .write_enable(write_enable),
    .rs1_data(rs1_data), .rs2_data(rs2_data)
  );

  mips_reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .WRITE_BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .rd(rd),
    .write_data(write_data), .write_enable(write_enable),
    .rs1_data(rs1_data_nb), .rs2_data(rs2_data_nb)
  );

  typedef struct {
    logic        r, w;
    logic [4:0]  d;
    logic [31:0] wd;
    logic [4:0]  a, b;
    logic [31:0] e1, e2, n1, n2;  // bypass / non-bypass expectations
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one cycle, check reads mid-cycle, then take the edge and update the model.
  task automatic step(input string nm, input logic r, input logic w, input logic [4:0] d,
                      input logic [31:0] wd, input logic [4:0] a, input logic [4:0] b,
                      input logic [31:0] e1, input logic [31:0] e2,
                      input logic [31:0] n1, input logic [31:0] n2);
    @(negedge clk);
    rst = r; write_enable = w; rd = d; write_data = wd; rs1 = a; rs2 = b;
    #1;
    chk({nm, ".rs1"},    rs1_data,    e1);
    chk({nm, ".rs2"},    rs2_data,    e2);
    chk({nm, ".rs1_nb"}, rs1_data_nb, n1);
    chk({nm, ".rs2_nb"}, rs2_data_nb, n2);
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    end else if (w === 1'b1 && d != 5'd0) begin
      mdl[d] = wd;
    end
  endtask

  function automatic logic [31:0] stored(input logic [4:0] a);
    return (a == 5'd0) ? 32'h0 : mdl[a];
  endfunction

  function automatic logic [31:0] fwd(input logic r, input logic w, input logic [4:0] d,
                                      input logic [31:0] wd, input logic [4:0] a);
    return (!r && w && d != 5'd0 && d == a) ? wd : stored(a);
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    //         r     w     d     wd            a     b     e1            e2            n1            n2
    tbl[0]  = '{1'b0, 1'b0, 5'd0, 32'h0,        5'd0, 5'd1, 32'h0,        32'h0,        32'h0,        32'h0};
    tbl[1]  = '{1'b0, 1'b0, 5'd0, 32'h0,        5'd31,5'd31,32'h0,        32'h0,        32'h0,        32'h0};
    tbl[2]  = '{1'b0, 1'b1, 5'd1, 32'hA5A5A5A5, 5'd2, 5'd3, 32'h0,        32'h0,        32'h0,        32'h0};
    tbl[3]  = '{1'b0, 1'b1, 5'd2, 32'h5A5A5A5A, 5'd1, 5'd2, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'hA5A5A5A5, 32'h0};
    tbl[4]  = '{1'b0, 1'b0, 5'd0, 32'h0,        5'd1, 5'd2, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'hA5A5A5A5, 32'h5A5A5A5A};
    tbl[5]  = '{1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 32'h0,        32'h0,        32'h0,        32'h0};
    tbl[6]  = '{1'b0, 1'b0, 5'd3, 32'hDEADBEEF, 5'd0, 5'd3, 32'h0,        32'h0,        32'h0,        32'h0};
    tbl[7]  = '{1'b0, 1'b0, 5'd0, 32'h0,        5'd3, 5'd3, 32'h0,        32'h0,        32'h0,        32'h0};
    tbl[8]  = '{1'b0, 1'b0, 5'd0, 32'h0,        5'd1, 5'd1, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5};
    tbl[9]  = '{1'b0, 1'b1, 5'd5, 32'h12345678, 5'd5, 5'd1, 32'h12345678, 32'hA5A5A5A5, 32'h0,        32'hA5A5A5A5};
    tbl[10] = '{1'b0, 1'b0, 5'd0, 32'h0,        5'd5, 5'd5, 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678};

    rst = 1'b1; write_enable = 1'b0; rd = '0; write_data = '0; rs1 = '0; rs2 = '0;
    @(posedge clk);

    for (int i = 0; i < 11; i++)
      step($sformatf("vec%0d", i), tbl[i].r, tbl[i].w, tbl[i].d, tbl[i].wd, tbl[i].a, tbl[i].b,
           tbl[i].e1, tbl[i].e2, tbl[i].n1, tbl[i].n2);

    // Unknown write index with the strobe low must leave storage untouched
    step("xaddr", 1'b0, 1'b0, 5'bxxxxx, 32'hCAFEF00D, 5'd1, 5'd5,
         32'hA5A5A5A5, 32'h12345678, 32'hA5A5A5A5, 32'h12345678);
    step("xaddr_after", 1'b0, 1'b0, 5'd0, 32'h0, 5'd2, 5'd5,
         32'h5A5A5A5A, 32'h12345678, 32'h5A5A5A5A, 32'h12345678);

    // Reset beats a simultaneous write, and the bypass is suppressed during reset
    step("rst_prio", 1'b1, 1'b1, 5'd7, 32'h1, 5'd7, 5'd1,
         32'h0, 32'hA5A5A5A5, 32'h0, 32'hA5A5A5A5);
    step("post_rst_a", 1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd1, 32'h0, 32'h0, 32'h0, 32'h0);
    step("post_rst_b", 1'b0, 1'b0, 5'd0, 32'h0, 5'd2, 5'd5, 32'h0, 32'h0, 32'h0, 32'h0);

    for (int i = 0; i < 300; i++) begin
      logic        r, w;
      logic [4:0]  d, a, b;
      logic [31:0] wd;
      r  = ($urandom_range(0, 31) == 0);
      w  = ($urandom_range(0, 3) != 0);
      d  = 5'($urandom_range(0, 31));
      wd = $urandom;
      a  = ($urandom_range(0, 3) == 0) ? d : 5'($urandom_range(0, 31));
      b  = ($urandom_range(0, 3) == 0) ? d : 5'($urandom_range(0, 31));
      step($sformatf("rnd%0d", i), r, w, d, wd, a, b,
           fwd(r, w, d, wd, a), fwd(r, w, d, wd, b), stored(a), stored(b));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
